btn_ctrl: RTL and testbench

// - Conditions the raw front-panel push buttons (btn[], active-low, asynchronous) before they reach the CPU controls PIO.
// - Per button: 2-FF synchronizer, counter debounce, long-press detect, one-cycle press/release strobes, sticky event flags with ack.
// - Runs on clk27 alongside ir_rcv; output replaces the raw btn field in pio_1_controls_in.

---
 rtl/btn_ctrl.sv | 157 +++++++++++++++
 tb/tb_btn_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_ctrl.sv
// btn_ctrl: per-button 2-FF sync, counter debounce, long-press detect, press/release strobes, sticky events.
// Strobes land 2+DEBOUNCE_CYC cycles after a raw edge; define BTN_REPEAT_EN for auto-repeat while long-pressed.
module btn_ctrl #(
  parameter int NUM_BTN       = 2,
  parameter int DEBOUNCE_CYC  = 270000,
  parameter int LONGPRESS_CYC = 27000000,
  parameter int REPEAT_CYC    = 5400000
) (
  input  logic               clk27,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn,
  input  logic [NUM_BTN-1:0] btn_ack,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic [NUM_BTN-1:0] btn_event
);
  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam int HW = $clog2(LONGPRESS_CYC);
`ifdef BTN_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYC);
`endif

  if (DEBOUNCE_CYC < 2 || LONGPRESS_CYC <= DEBOUNCE_CYC || REPEAT_CYC < 2) begin : g_param_check
    $error("btn_ctrl: illegal timing parameters");
  end

  typedef enum logic [1:0] {REL, HELD, LONG} fsm_t;

  // Synchronizer holds raw polarity so reset (all ones) means released.
  logic [NUM_BTN-1:0] r_sync1, r_sync2, w_s;

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = ~r_sync2;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    logic [CW-1:0] r_cnt;
    logic          r_state, w_tog;
    fsm_t          r_fsm, w_fsm_nxt;
    logic [HW-1:0] r_hold, w_hold_nxt;
    logic          r_press, w_press_nxt;
    logic          r_release, w_release_nxt;
    logic          r_long, w_long_nxt;
    logic          r_event;
`ifdef BTN_REPEAT_EN
    logic [RW-1:0] r_rep, w_rep_nxt;
`endif

    assign w_tog = (w_s[gi] != r_state) && (r_cnt == CW'(DEBOUNCE_CYC - 1));

    always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt   <= '0;
        r_state <= 1'b0;
      end else begin
        if ((w_s[gi] == r_state) || w_tog) r_cnt <= '0;
        else                               r_cnt <= r_cnt + CW'(1);
        if (w_tog) r_state <= ~r_state;
      end
    end

    always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
        r_fsm     <= REL;
        r_hold    <= '0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        r_event   <= 1'b0;
`ifdef BTN_REPEAT_EN
        r_rep     <= '0;
`endif
      end else begin
        r_fsm     <= w_fsm_nxt;
        r_hold    <= w_hold_nxt;
        r_press   <= w_press_nxt;
        r_release <= w_release_nxt;
        r_long    <= w_long_nxt;
        // A press strobe seen in the same cycle as an ack keeps the flag set.
        r_event   <= (r_event & ~btn_ack[gi]) | r_press;
`ifdef BTN_REPEAT_EN
        r_rep     <= w_rep_nxt;
`endif
      end
    end

    always_comb begin
      w_fsm_nxt     = r_fsm;
      w_hold_nxt    = r_hold;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      w_long_nxt    = r_long;
`ifdef BTN_REPEAT_EN
      w_rep_nxt     = r_rep;
`endif
      case (r_fsm)
        REL: begin
          if (w_tog && !r_state) begin
            w_press_nxt = 1'b1;
            w_hold_nxt  = '0;
            w_fsm_nxt   = HELD;
          end
        end
        HELD: begin
          if (w_tog && r_state) begin
            w_release_nxt = 1'b1;
            w_fsm_nxt     = REL;
          end else if (r_hold == HW'(LONGPRESS_CYC - 1)) begin
            w_long_nxt = 1'b1;
`ifdef BTN_REPEAT_EN
            w_rep_nxt  = '0;
`endif
            w_fsm_nxt  = LONG;
          end else begin
            w_hold_nxt = r_hold + HW'(1);
          end
        end
        LONG: begin
          if (w_tog && r_state) begin
            w_release_nxt = 1'b1;
            w_long_nxt    = 1'b0;
`ifdef BTN_REPEAT_EN
            w_rep_nxt     = '0;
`endif
            w_fsm_nxt     = REL;
          end
`ifdef BTN_REPEAT_EN
          else if (r_rep == RW'(REPEAT_CYC - 1)) begin
            w_press_nxt = 1'b1;
            w_rep_nxt   = '0;
          end else begin
            w_rep_nxt = r_rep + RW'(1);
          end
`endif
        end
        default: w_fsm_nxt = REL;
      endcase
    end

    assign btn_state[gi]   = r_state;
    assign btn_press[gi]   = r_press;
    assign btn_release[gi] = r_release;
    assign btn_long[gi]    = r_long;
    assign btn_event[gi]   = r_event;
  end

endmodule

// File: tb/tb_btn_ctrl.sv
// Self-checking bench for btn_ctrl: directed scenarios with literal expectations plus
// randomized button/ack traffic compared every cycle against a timestamp-based model.
module tb_btn_ctrl;
  localparam int NB = 2;
  localparam int D  = 8;
  localparam int L  = 64;
  localparam int R  = 16;

  logic          clk27   = 1'b0;
  logic          reset_n = 1'b0;
  logic [NB-1:0] btn     = '1;
  logic [NB-1:0] btn_ack = '0;
  logic [NB-1:0] btn_state, btn_press, btn_release, btn_long, btn_event;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b1;

  btn_ctrl #(
    .NUM_BTN(NB), .DEBOUNCE_CYC(D), .LONGPRESS_CYC(L), .REPEAT_CYC(R)
  ) dut (
    .clk27      (clk27),
    .reset_n    (reset_n),
    .btn        (btn),
    .btn_ack    (btn_ack),
    .btn_state  (btn_state),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long),
    .btn_event  (btn_event)
  );

  always #5 clk27 = ~clk27;

  // Model: raw pressed samples per edge; accepted level flips once the synced view
  // (raw delayed two edges) has disagreed with it for D consecutive edges.
  // Long/repeat are derived from the cycle stamp of the accepted press.
  bit            hist [NB][D+2];
  logic [NB-1:0] m_state = '0, m_press = '0, m_release = '0, m_long = '0, m_event = '0;
  int            cyc = 0;
  int            press_cyc [NB];
  int            held;
  bit            all_diff;

  always @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      cyc = 0;
      m_state = '0; m_press = '0; m_release = '0; m_long = '0; m_event = '0;
      for (int i = 0; i < NB; i++) begin
        press_cyc[i] = 0;
        for (int k = 0; k < D + 2; k++) hist[i][k] = 1'b0;
      end
    end else begin
      cyc = cyc + 1;
      m_event = (m_event & ~btn_ack) | m_press;
      for (int i = 0; i < NB; i++) begin
        for (int k = D + 1; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = ~btn[i];
        all_diff = 1'b1;
        for (int k = 2; k < D + 2; k++) if (hist[i][k] == m_state[i]) all_diff = 1'b0;
        m_press[i] = 1'b0;
        m_release[i] = 1'b0;
        if (all_diff) begin
          if (!m_state[i]) begin
            m_state[i] = 1'b1; m_press[i] = 1'b1; press_cyc[i] = cyc;
          end else begin
            m_state[i] = 1'b0; m_release[i] = 1'b1;
          end
        end
        held = cyc - press_cyc[i];
        m_long[i] = m_state[i] && (held >= L);
`ifdef BTN_REPEAT_EN
        if (m_state[i] && held >= L + R && ((held - L) % R) == 0) m_press[i] = 1'b1;
`endif
      end
    end
  end

  always @(negedge clk27) begin
    if (chk_en) begin
      checks++;
      if ({btn_state, btn_press, btn_release, btn_long, btn_event} !==
          {m_state, m_press, m_release, m_long, m_event}) begin
        errors++;
        $display("FAIL model_cmp t=%0t dut st=%b pr=%b rl=%b lg=%b ev=%b required st=%b pr=%b rl=%b lg=%b ev=%b",
                 $time, btn_state, btn_press, btn_release, btn_long, btn_event,
                 m_state, m_press, m_release, m_long, m_event);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk27);
      #1;
    end
  endtask

  // sel: 0 press, 1 release, 2 long. Returns cycles waited, -1 when the bound expires.
  task automatic wait_for(input int sel, input int b, input int limit, output int n);
    logic hit;
    n = -1;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk27);
      #1;
      case (sel)
        0:       hit = btn_press[b];
        1:       hit = btn_release[b];
        default: hit = btn_long[b];
      endcase
      if (hit) begin
        n = c;
        break;
      end
    end
  endtask

  int            n, bad, len;
  logic [NB-1:0] v;

  initial begin
    btn = '1;
    btn_ack = '0;
    reset_n = 1'b0;
    tick(3);
    check("reset_outputs", int'({btn_state, btn_press, btn_release, btn_long, btn_event}), 0);
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick(1);
      if (|{btn_state, btn_press, btn_release, btn_long, btn_event}) bad++;
    end
    check("idle_after_reset", bad, 0);

    // Short glitch must be rejected.
    btn[0] = 1'b0;
    tick(5);
    btn[0] = 1'b1;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      tick(1);
      if (btn_state[0] || btn_press[0]) bad++;
    end
    check("glitch_rejected", bad, 0);

    // Accepted press: latency, single-cycle strobe, event set.
    btn[0] = 1'b0;
    wait_for(0, 0, 40, n);
    check("press_latency", n, 10);
    check("state_on_press", int'(btn_state[0]), 1);
    check("event_before_set", int'(btn_event[0]), 0);
    tick(1);
    check("press_one_cycle", int'(btn_press[0]), 0);
    check("event_set", int'(btn_event[0]), 1);
    tick(3);
    check("event_sticky", int'(btn_event[0]), 1);
    btn_ack[0] = 1'b1;
    tick(1);
    btn_ack[0] = 1'b0;
    check("event_acked", int'(btn_event[0]), 0);

    // Release.
    btn[0] = 1'b1;
    wait_for(1, 0, 40, n);
    check("release_latency", n, 10);
    check("state_after_release", int'(btn_state[0]), 0);
    check("long_after_release", int'(btn_long[0]), 0);
    tick(1);
    check("release_one_cycle", int'(btn_release[0]), 0);

    // Ack in the strobe cycle loses to the set.
    btn[0] = 1'b0;
    wait_for(0, 0, 40, n);
    check("press2_latency", n, 10);
    btn_ack[0] = 1'b1;
    tick(1);
    btn_ack[0] = 1'b0;
    check("set_wins_over_ack", int'(btn_event[0]), 1);
    btn[0] = 1'b1;
    wait_for(1, 0, 40, n);
    check("release2_latency", n, 10);

    // Long press and auto-repeat on button 1.
    btn[1] = 1'b0;
    wait_for(0, 1, 40, n);
    check("press1_latency", n, 10);
    wait_for(2, 1, 100, n);
    check("long_latency", n, 64);
    bad = 0;
    for (int c = 0; c < 70; c++) begin
      tick(1);
      if (btn_press[1]) bad++;
    end
`ifdef BTN_REPEAT_EN
    check("repeat_count", bad, 4);
`else
    check("repeat_count", bad, 0);
`endif
    btn[1] = 1'b1;
    wait_for(1, 1, 40, n);
    check("release1_latency", n, 10);
    check("long1_cleared", int'(btn_long[1]), 0);

    // Async reset while long-pressed.
    btn[0] = 1'b0;
    wait_for(2, 0, 120, n);
    check("long0_reached", n, 74);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_clears", int'({btn_state, btn_press, btn_release, btn_long, btn_event}), 0);
    tick(2);
    reset_n = 1'b1;
    wait_for(0, 0, 40, n);
    check("repress_after_reset", n, 10);
    wait_for(2, 0, 100, n);
    check("relong_after_reset", n, 64);
    btn[0] = 1'b1;
    tick(20);

    // Randomized traffic, checked every cycle by the model.
    for (int seg = 0; seg < 60; seg++) begin
      v = NB'($urandom);
      case ($urandom_range(0, 2))
        0:       len = $urandom_range(1, 7);
        1:       len = $urandom_range(8, 30);
        default: len = $urandom_range(65, 110);
      endcase
      btn = v;
      for (int c = 0; c < len; c++) begin
        btn_ack = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
        tick(1);
      end
    end
    btn = '1;
    btn_ack = '0;
    tick(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
